// File: rtl/ram8_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram8_fifo_ctrl_pkg
// Shared definitions for the RAM-backed FIFO controller:
//   DATA_W_DEFAULT  default word width (matches the external RAM data width)
//   ADDR_W_DEFAULT  default RAM address width (RAM depth = 2**ADDR_W)
//   ramOp_e         the one RAM operation selected each cycle
// ---------------------------------------------------------------------------
package ram8_fifo_ctrl_pkg;

   localparam int DATA_W_DEFAULT = 16;
   localparam int ADDR_W_DEFAULT = 3;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_WRITE = 2'd1,
      OP_READ  = 2'd2
   } ramOp_e;

endpackage

// File: rtl/ram8_fifo_ctrl_wrap_ptr.sv
// ---------------------------------------------------------------------------
// ram8_fifo_ctrl_wrap_ptr
// ADDR_W-bit modulo counter used for the FIFO read and write pointers.
// It rolls from 2**ADDR_W-1 back to 0 on its own, so no compare is needed.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (pointer to 0)
//   clear  synchronous clear (pointer to 0), wins over inc
//   inc    advance the pointer by one at the next edge
//   ptr    current pointer value
// ---------------------------------------------------------------------------
module ram8_fifo_ctrl_wrap_ptr
   import ram8_fifo_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              inc,
   output logic [ADDR_W-1:0] ptr
);

   logic [ADDR_W-1:0] ptrQ;

   // The pointer register. Clear beats increment so that a flush issued in the
   // same cycle as a RAM access leaves the pointer at zero. Natural binary
   // overflow gives the modulo-DEPTH wrap for free.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptrQ <= '0;
      end else if (clear) begin
         ptrQ <= '0;
      end else if (inc) begin
         ptrQ <= ptrQ + 1'b1;
      end
   end

   assign ptr = ptrQ;

endmodule

// File: rtl/ram8_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram8_fifo_ctrl
// Turns an external single-port RAM (combinational read, clocked write on
// mem_load) into a FIFO with valid/ready on both sides. Every word goes
// through the RAM; one output holding register (out_data/out_valid) adds one
// more entry, so the FIFO holds up to DEPTH+1 words.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   clear            synchronous flush of RAM contents and held word
//   in_data/valid    push side, accepted when in_valid && in_ready
//   in_ready
//   out_data/valid   pop side (registered), accepted when
//   out_ready        out_valid && out_ready
//   mem_addr/in/load RAM address, write data, write enable
//   mem_out          RAM combinational read data for mem_addr
//   level            words held: RAM count plus the held output word
// ---------------------------------------------------------------------------
module ram8_fifo_ctrl
   import ram8_fifo_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_in,
   output logic              mem_load,
   input  logic [DATA_W-1:0] mem_out,
   output logic [ADDR_W:0]   level
);

   localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

   ramOp_e            opSel;
   logic [ADDR_W:0]   memCntQ;
   logic              outValidQ;
   logic [DATA_W-1:0] outDataQ;
   logic [ADDR_W-1:0] wrPtr;
   logic [ADDR_W-1:0] rdPtr;
   logic              wrInc;
   logic              rdInc;
   logic              ramHasWord;
   logic              ramHasRoom;
   logic              popNow;

   assign ramHasWord = (memCntQ != '0);
   assign ramHasRoom = (memCntQ < DEPTH_CNT);
   assign popNow     = outValidQ && out_ready;

   // Pick the single RAM operation for this cycle. Refilling the output
   // register has priority over accepting a push: once a word sits in the RAM
   // and the holding register is free (or being popped), we read it out. Only
   // when no refill is needed does the port go to the producer. With nothing
   // to do the address rests on the read pointer.
   always_comb begin
      opSel    = OP_IDLE;
      mem_addr = rdPtr;
      if (ramHasWord && (!outValidQ || out_ready)) begin
         opSel    = OP_READ;
         mem_addr = rdPtr;
      end else if (in_valid && ramHasRoom) begin
         opSel    = OP_WRITE;
         mem_addr = wrPtr;
      end
   end

   // Handshake and write enable. Both are gated by reset and clear so that no
   // word is accepted or written into the RAM during a reset or flush cycle.
   // The producer can only be ready when the port is not taken by a refill.
   always_comb begin
      in_ready = reset && !clear && (opSel != OP_READ) && ramHasRoom;
      mem_load = reset && !clear && (opSel == OP_WRITE);
   end

   assign wrInc = (opSel == OP_WRITE) && !clear;
   assign rdInc = (opSel == OP_READ) && !clear;

   ram8_fifo_ctrl_wrap_ptr #(
      .ADDR_W (ADDR_W)
   ) uWrPtr (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (wrInc),
      .ptr   (wrPtr)
   );

   ram8_fifo_ctrl_wrap_ptr #(
      .ADDR_W (ADDR_W)
   ) uRdPtr (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (rdInc),
      .ptr   (rdPtr)
   );

   // RAM occupancy and the output holding register. A READ moves the RAM head
   // into the holding register (replacing any word being popped at the same
   // edge). A WRITE grows the RAM count; since a WRITE only happens when no
   // refill was possible, a pop in that cycle simply empties the holding
   // register. A flush empties everything but leaves the last out_data value
   // in place, it just stops being valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         memCntQ   <= '0;
         outValidQ <= 1'b0;
         outDataQ  <= '0;
      end else if (clear) begin
         memCntQ   <= '0;
         outValidQ <= 1'b0;
      end else begin
         case (opSel)
            OP_READ: begin
               outDataQ  <= mem_out;
               outValidQ <= 1'b1;
               memCntQ   <= memCntQ - 1'b1;
            end
            OP_WRITE: begin
               memCntQ <= memCntQ + 1'b1;
               if (popNow) begin
                  outValidQ <= 1'b0;
               end
            end
            default: begin
               if (popNow) begin
                  outValidQ <= 1'b0;
               end
            end
         endcase
      end
   end

   assign out_data  = outDataQ;
   assign out_valid = outValidQ;
   assign mem_in    = in_data;
   assign level     = memCntQ + {{ADDR_W{1'b0}}, outValidQ};

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram8_fifo_ctrl
// Bench for ram8_fifo_ctrl. Provides the external 8x16 RAM, drives directed
// scenarios and a long random run. Expected values come from a queue-based
// model of "words in RAM" plus "word held at the output", updated with the
// FIFO's rules, and from an end-to-end scoreboard of accepted pushes.
// ---------------------------------------------------------------------------
module tb_ram8_fifo_ctrl;

   logic        clk;
   logic        rstN;
   logic        clear;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  mem_addr;
   logic [15:0] mem_in;
   logic        mem_load;
   logic [15:0] mem_out;
   logic [3:0]  level;

   logic [15:0] ramArr [8];

   int totalChecks = 0;
   int badChecks   = 0;
   int popCount    = 0;

   logic [15:0] mdlRam [$];
   logic        mdlHeldValid;
   logic [15:0] mdlHeldData;
   logic [15:0] sb [$];

   logic        lastIn;
   logic        lastOut;
   logic        lastOutValid;
   logic [15:0] lastOutData;

   ram8_fifo_ctrl dut (
      .clk       (clk),
      .reset     (rstN),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mem_addr  (mem_addr),
      .mem_in    (mem_in),
      .mem_load  (mem_load),
      .mem_out   (mem_out),
      .level     (level)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // External RAM: clocked write on mem_load, combinational read.
   always @(posedge clk) begin
      if (mem_load) begin
         ramArr[mem_addr] <= mem_in;
      end
   end

   assign mem_out = ramArr[mem_addr];

   // Safety net so the run can never hang.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic resetModel();
      mdlRam.delete();
      sb.delete();
      mdlHeldValid = 1'b0;
      mdlHeldData  = 16'h0000;
   endtask

   // One clock cycle: drive inputs at the falling edge, check outputs 1 time
   // unit later, advance the model for the coming rising edge, and return at
   // the next falling edge.
   task automatic applyStimulus(input logic iv, input logic [15:0] d, input logic ordy, input logic clr);
      logic        mdlRead;
      logic        mdlReady;
      logic [15:0] expWord;
      int          sz;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      clear     = clr;
      #1;
      sz       = mdlRam.size();
      mdlRead  = rstN && (sz > 0) && (!mdlHeldValid || ordy);
      mdlReady = rstN && !clr && !mdlRead && (sz < 8);
      checkOutput("inReady",  32'(in_ready),  32'(mdlReady));
      checkOutput("memLoad",  32'(mem_load),  32'(mdlReady && iv));
      checkOutput("outValid", 32'(out_valid), 32'(mdlHeldValid));
      checkOutput("outData",  32'(out_data),  32'(mdlHeldData));
      checkOutput("level",    32'(level),     32'(sz + int'(mdlHeldValid)));
      checkOutput("levelMax", 32'(level <= 4'd9), 32'(1'b1));
      lastIn       = in_valid && in_ready;
      lastOut      = out_valid && out_ready;
      lastOutValid = out_valid;
      lastOutData  = out_data;
      if (lastOut) begin
         popCount++;
         checkOutput("popHasWord", 32'(sb.size() > 0), 32'(1'b1));
         if (sb.size() > 0) begin
            expWord = sb.pop_front();
            checkOutput("sbOrder", 32'(out_data), 32'(expWord));
         end
      end
      if (!rstN || clr) begin
         sb.delete();
      end else if (lastIn) begin
         sb.push_back(d);
      end
      if (!rstN) begin
         mdlRam.delete();
         mdlHeldValid = 1'b0;
         mdlHeldData  = 16'h0000;
      end else if (clr) begin
         mdlRam.delete();
         mdlHeldValid = 1'b0;
      end else if (mdlRead) begin
         mdlHeldData  = mdlRam.pop_front();
         mdlHeldValid = 1'b1;
      end else begin
         if (mdlHeldValid && ordy) begin
            mdlHeldValid = 1'b0;
         end
         if (iv && (sz < 8)) begin
            mdlRam.push_back(d);
         end
      end
      @(negedge clk);
   endtask

   task automatic pushWord(input logic [15:0] d, input logic ordy);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, d, ordy, 1'b0);
         if (lastIn) begin
            return;
         end
      end
      checkOutput("pushTimeout", 32'(lastIn), 32'(1'b1));
   endtask

   task automatic popWord(input string tag, input logic [15:0] exp);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
         if (lastOut) begin
            checkOutput(tag, 32'(lastOutData), 32'(exp));
            return;
         end
      end
      checkOutput("popTimeout", 32'(lastOut), 32'(1'b1));
   endtask

   initial begin
      int startPops;
      for (int i = 0; i < 8; i++) begin
         ramArr[i] = 16'h0000;
      end
      rstN      = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      out_ready = 1'b0;
      resetModel();
      @(negedge clk);

      // Reset held with a push pending: nothing may be accepted or written.
      applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
      checkOutput("rstLevel", 32'(level), 32'd0);

      // Release, push one word, it shows up two edges later.
      rstN = 1'b1;
      applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
      checkOutput("firstReady", 32'(lastIn), 32'(1'b1));
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("lat1Valid", 32'(lastOutValid), 32'(1'b0));
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("lat2Valid", 32'(lastOutValid), 32'(1'b1));
      checkOutput("lat2Data",  32'(lastOutData),  32'h1234);
      popWord("latPop", 16'h1234);

      // Fill to DEPTH+1 with the consumer stalled, then drain in order.
      for (int k = 1; k <= 9; k++) begin
         pushWord(16'(k), 1'b0);
      end
      applyStimulus(1'b1, 16'h000A, 1'b0, 1'b0);
      checkOutput("fullLevel", 32'(level), 32'd9);
      checkOutput("fullReady", 32'(in_ready), 32'(1'b0));
      applyStimulus(1'b1, 16'h000A, 1'b0, 1'b0);
      checkOutput("fullHeld", 32'(lastIn), 32'(1'b0));
      for (int k = 1; k <= 9; k++) begin
         popWord("drainOrder", 16'(k));
      end

      // Streaming with the consumer always ready; pointers wrap twice.
      startPops = popCount;
      for (int k = 0; k < 20; k++) begin
         pushWord(16'(16'h0100 + k), 1'b1);
      end
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      end
      checkOutput("streamPops", 32'(popCount - startPops), 32'd20);

      // Flush with a push pending: the pushed word must never come out.
      for (int k = 0; k < 4; k++) begin
         pushWord(16'(16'hA000 + k), 1'b0);
      end
      checkOutput("clrLevelBefore", 32'(level), 32'd4);
      applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b1);
      checkOutput("clrLevel", 32'(level), 32'd0);
      checkOutput("clrValid", 32'(out_valid), 32'(1'b0));
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      pushWord(16'hB001, 1'b0);
      pushWord(16'hB002, 1'b0);
      popWord("clrAfter1", 16'hB001);
      popWord("clrAfter2", 16'hB002);

      // Asynchronous reset in the middle of a cycle with five words held.
      for (int k = 0; k < 5; k++) begin
         pushWord(16'(16'hC000 + k), 1'b0);
      end
      checkOutput("rstMidLevelBefore", 32'(level), 32'd5);
      in_valid = 1'b1;
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("rstMidValid", 32'(out_valid), 32'(1'b0));
      checkOutput("rstMidData",  32'(out_data),  32'h0000);
      checkOutput("rstMidLevel", 32'(level),     32'd0);
      checkOutput("rstMidLoad",  32'(mem_load),  32'(1'b0));
      checkOutput("rstMidReady", 32'(in_ready),  32'(1'b0));
      resetModel();
      @(negedge clk);
      applyStimulus(1'b1, 16'h5555, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'h5555, 1'b1, 1'b0);
      rstN = 1'b1;

      // Long random run against the model and scoreboard.
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
